ddr3_dfi_responder: RTL and testbench

//  Synthesisable DDR3-device stand-in on the DFI side of the memory controller: decodes DFI commands,

---
 rtl/ddr3_dfi_responder_if.sv | 44 ++++
 rtl/ddr3_dfi_responder.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_ddr3_dfi_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_dfi_responder_if.sv
// DFI bundle between a memory controller (master) and the DDR3 responder (slave):
// command/address, write data, read data and the calibration handshake.
interface ddr3_dfi_responder_if #(
    parameter int unsigned DDR_ROW_BITS = 15,
    parameter int unsigned DDR_DQ_WIDTH = 16
);
    localparam int unsigned RSB = DDR_ROW_BITS - 1;
    localparam int unsigned MSB = 2 * DDR_DQ_WIDTH - 1;
    localparam int unsigned SSB = (2 * DDR_DQ_WIDTH) / 8 - 1;

    logic           dfi_rst_ni;
    logic           dfi_cke_i;
    logic           dfi_cs_ni;
    logic           dfi_ras_ni;
    logic           dfi_cas_ni;
    logic           dfi_we_ni;
    logic           dfi_odt_i;
    logic [2:0]     dfi_bank_i;
    logic [RSB:0]   dfi_addr_i;
    logic           dfi_wstb_i;
    logic           dfi_wren_i;
    logic [SSB:0]   dfi_mask_i;
    logic [MSB:0]   dfi_data_i;
    logic           dfi_rden_i;
    logic           dfi_rvld_o;
    logic           dfi_last_o;
    logic [MSB:0]   dfi_data_o;
    logic           dfi_align_i;
    logic           dfi_calib_o;

    modport master (
        output dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
               dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i,
               dfi_data_i, dfi_rden_i, dfi_align_i,
        input  dfi_rvld_o, dfi_last_o, dfi_data_o, dfi_calib_o
    );

    modport slave (
        input  dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
               dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i,
               dfi_data_i, dfi_rden_i, dfi_align_i,
        output dfi_rvld_o, dfi_last_o, dfi_data_o, dfi_calib_o
    );
endinterface

// File: rtl/ddr3_dfi_responder.sv
// DDR3 device stand-in on the DFI side: command decode, per-bank open rows, RAM-backed BL8 bursts,
// fixed-latency read return and calibration handshake. Define DFI_RESP_CHECK_EN to enable err_o.
module ddr3_dfi_responder #(
    parameter int unsigned DDR_ROW_BITS = 15,
    parameter int unsigned DDR_COL_BITS = 10,
    parameter int unsigned DDR_DQ_WIDTH = 16,
    parameter int unsigned MEM_ABITS    = 10,
    parameter int unsigned RD_LATENCY   = 3,
    parameter int unsigned CALIB_DELAY  = 16,
    parameter int unsigned CMD_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset,
    ddr3_dfi_responder_if.slave dfi,
    output logic                err_o
);
    localparam int unsigned PHY_DAT_BITS = 2 * DDR_DQ_WIDTH;
    localparam int unsigned PHY_STB_BITS = PHY_DAT_BITS / 8;
    localparam int unsigned MSB          = PHY_DAT_BITS - 1;
    localparam int unsigned RSB          = DDR_ROW_BITS - 1;
    localparam int unsigned CSB          = DDR_COL_BITS - 1;
    localparam int unsigned FULL_BITS    = 3 + DDR_ROW_BITS + DDR_COL_BITS - 1;
    localparam int unsigned BASE_BITS    = MEM_ABITS - 2;
    localparam int unsigned PW           = $clog2(CMD_DEPTH);
    localparam int unsigned CW           = $clog2(CALIB_DELAY);
    localparam int unsigned MEM_WORDS    = 1 << MEM_ABITS;
    localparam int unsigned AP_BIT       = 10;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } dfi_cmd_e;

    typedef enum logic [1:0] {
        CAL_IDLE,
        CAL_WAIT,
        CAL_DONE
    } cal_state_e;

    // ------------------------------------------------------------------ command decode
    dfi_cmd_e   cmd;
    logic       cmd_en;
    logic       is_act;
    logic       is_pre;
    logic       is_rd;
    logic       is_wr;
    logic [2:0] bank;
    logic       ap;

    assign cmd_en = dfi.dfi_rst_ni & dfi.dfi_cke_i & ~dfi.dfi_cs_ni;
    assign cmd    = dfi_cmd_e'({dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni});
    assign is_act = cmd_en && (cmd == CMD_ACT);
    assign is_pre = cmd_en && (cmd == CMD_PRE);
    assign is_rd  = cmd_en && (cmd == CMD_RD);
    assign is_wr  = cmd_en && (cmd == CMD_WR);
    assign bank   = dfi.dfi_bank_i;
    assign ap     = dfi.dfi_addr_i[AP_BIT];

    // ------------------------------------------------------------------ open-row tracking
    logic [RSB:0] row_q [8];
    logic [7:0]   open_q;
    logic [7:0]   open_d;

    always_comb begin
        open_d = open_q;
        if (is_act) begin
            open_d[bank] = 1'b1;
        end
        if (is_pre) begin
            if (ap) begin
                open_d = '0;
            end else begin
                open_d[bank] = 1'b0;
            end
        end
        if ((is_rd || is_wr) && ap) begin
            open_d[bank] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !dfi.dfi_rst_ni) begin
            open_q <= '0;
        end else begin
            open_q <= open_d;
        end
    end

    // Row registers are never cleared: a RD/WR to a closed bank reuses the stale row.
    always_ff @(posedge clock) begin
        if (is_act) begin
            row_q[bank] <= dfi.dfi_addr_i;
        end
    end

    logic [FULL_BITS-1:0] cmd_full;
    logic [BASE_BITS-1:0] cmd_base;

    assign cmd_full = {bank, row_q[bank], dfi.dfi_addr_i[CSB:1]};
    assign cmd_base = cmd_full[MEM_ABITS-1:2];

    // ------------------------------------------------------------------ read command queue
    logic [BASE_BITS-1:0] rdq_q [CMD_DEPTH];
    logic [PW:0]          rdq_wp_q;
    logic [PW:0]          rdq_rp_q;
    logic [1:0]           rd_beat_q;
    logic                 rdq_empty;
    logic                 rdq_full;
    logic                 rd_hit;
    logic                 rd_pop;
    logic                 rd_push;
    logic [MEM_ABITS-1:0] rd_word;

    assign rdq_empty = (rdq_wp_q == rdq_rp_q);
    assign rdq_full  = (rdq_wp_q[PW] != rdq_rp_q[PW]) && (rdq_wp_q[PW-1:0] == rdq_rp_q[PW-1:0]);
    assign rd_hit    = dfi.dfi_rden_i & dfi.dfi_rst_ni & ~rdq_empty;
    assign rd_pop    = rd_hit & (rd_beat_q == 2'd3);
    assign rd_push   = is_rd & (~rdq_full | rd_pop);
    assign rd_word   = {rdq_q[rdq_rp_q[PW-1:0]], rd_beat_q};

    always_ff @(posedge clock) begin
        if (reset || !dfi.dfi_rst_ni) begin
            rdq_wp_q  <= '0;
            rdq_rp_q  <= '0;
            rd_beat_q <= '0;
        end else begin
            if (rd_push) begin
                rdq_q[rdq_wp_q[PW-1:0]] <= cmd_base;
                rdq_wp_q                <= rdq_wp_q + 1'b1;
            end
            if (rd_hit) begin
                rd_beat_q <= rd_beat_q + 2'd1;
            end
            if (rd_pop) begin
                rdq_rp_q <= rdq_rp_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ write command queue
    logic [BASE_BITS-1:0] wrq_q [CMD_DEPTH];
    logic [PW:0]          wrq_wp_q;
    logic [PW:0]          wrq_rp_q;
    logic [1:0]           wr_beat_q;
    logic                 wrq_empty;
    logic                 wrq_full;
    logic                 wr_hit;
    logic                 wr_pop;
    logic                 wr_push;
    logic [MEM_ABITS-1:0] wr_word;

    assign wrq_empty = (wrq_wp_q == wrq_rp_q);
    assign wrq_full  = (wrq_wp_q[PW] != wrq_rp_q[PW]) && (wrq_wp_q[PW-1:0] == wrq_rp_q[PW-1:0]);
    assign wr_hit    = dfi.dfi_wren_i & dfi.dfi_rst_ni & ~wrq_empty;
    assign wr_pop    = wr_hit & (wr_beat_q == 2'd3);
    assign wr_push   = is_wr & (~wrq_full | wr_pop);
    assign wr_word   = {wrq_q[wrq_rp_q[PW-1:0]], wr_beat_q};

    always_ff @(posedge clock) begin
        if (reset || !dfi.dfi_rst_ni) begin
            wrq_wp_q  <= '0;
            wrq_rp_q  <= '0;
            wr_beat_q <= '0;
        end else begin
            if (wr_push) begin
                wrq_q[wrq_wp_q[PW-1:0]] <= cmd_base;
                wrq_wp_q                <= wrq_wp_q + 1'b1;
            end
            if (wr_hit) begin
                wr_beat_q <= wr_beat_q + 2'd1;
            end
            if (wr_pop) begin
                wrq_rp_q <= wrq_rp_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ data RAM (read-first)
    logic [MSB:0] ram_q [MEM_WORDS];
    logic [MSB:0] ram_rd_q;

    always_ff @(posedge clock) begin
        if (wr_hit) begin
            for (int unsigned i = 0; i < PHY_STB_BITS; i++) begin
                if (!dfi.dfi_mask_i[i]) begin
                    ram_q[wr_word][i*8 +: 8] <= dfi.dfi_data_i[i*8 +: 8];
                end
            end
        end
        ram_rd_q <= ram_q[rd_word];
    end

    // ------------------------------------------------------------------ read return pipeline
    // Stage 0 is the RAM read register; stages 1..RD_LATENCY-1 form the delay line.
    logic [RD_LATENCY-1:0] rvld_q;
    logic [RD_LATENCY-1:0] rlast_q;
    logic                  rzero_q;
    logic [MSB:0]          rdat_q [RD_LATENCY-1:1];

    always_ff @(posedge clock) begin
        if (reset) begin
            rvld_q  <= '0;
            rlast_q <= '0;
            rzero_q <= 1'b0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rdat_q[i] <= '0;
            end
        end else begin
            rvld_q    <= {rvld_q[RD_LATENCY-2:0], dfi.dfi_rden_i};
            rlast_q   <= {rlast_q[RD_LATENCY-2:0], rd_pop};
            rzero_q   <= ~rd_hit;
            rdat_q[1] <= (rvld_q[0] && !rzero_q) ? ram_rd_q : '0;
            for (int unsigned i = 2; i < RD_LATENCY; i++) begin
                rdat_q[i] <= rdat_q[i-1];
            end
        end
    end

    assign dfi.dfi_rvld_o = rvld_q[RD_LATENCY-1];
    assign dfi.dfi_last_o = rlast_q[RD_LATENCY-1];
    assign dfi.dfi_data_o = rdat_q[RD_LATENCY-1];

    // ------------------------------------------------------------------ calibration FSM
    cal_state_e    cal_q;
    cal_state_e    cal_d;
    logic [CW-1:0] cal_cnt_q;
    logic [CW-1:0] cal_cnt_d;
    logic          align_q;

    // The counter is cleared on entry to WAIT, so DONE is reached CALIB_DELAY cycles after the rise.
    always_comb begin
        cal_d     = cal_q;
        cal_cnt_d = cal_cnt_q;
        unique case (cal_q)
            CAL_IDLE: begin
                if (dfi.dfi_align_i && !align_q) begin
                    cal_d     = CAL_WAIT;
                    cal_cnt_d = '0;
                end
            end
            CAL_WAIT: begin
                if (!dfi.dfi_align_i) begin
                    cal_d = CAL_IDLE;
                end else if (cal_cnt_q == CW'(CALIB_DELAY - 2)) begin
                    cal_d = CAL_DONE;
                end else begin
                    cal_cnt_d = cal_cnt_q + 1'b1;
                end
            end
            CAL_DONE: begin
                if (!dfi.dfi_align_i) begin
                    cal_d = CAL_IDLE;
                end
            end
            default: cal_d = CAL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cal_q     <= CAL_IDLE;
            cal_cnt_q <= '0;
            align_q   <= 1'b0;
        end else begin
            cal_q     <= cal_d;
            cal_cnt_q <= cal_cnt_d;
            align_q   <= dfi.dfi_align_i;
        end
    end

    assign dfi.dfi_calib_o = (cal_q == CAL_DONE);

    // ------------------------------------------------------------------ protocol checker
`ifdef DFI_RESP_CHECK_EN
    logic err_q;
    logic err_d;
    logic rd_drop;
    logic wr_drop;

    assign rd_drop = is_rd & rdq_full & ~rd_pop;
    assign wr_drop = is_wr & wrq_full & ~wr_pop;

    always_comb begin
        err_d = err_q;
        if (rd_drop || wr_drop) begin
            err_d = 1'b1;
        end
        if ((dfi.dfi_rden_i && !rd_hit) || (dfi.dfi_wren_i && !wr_hit)) begin
            err_d = 1'b1;
        end
        if ((is_rd || is_wr) && !open_q[bank]) begin
            err_d = 1'b1;
        end
        if (is_act && open_q[bank]) begin
            err_d = 1'b1;
        end
        if ((dfi.dfi_rden_i || dfi.dfi_wren_i) && !dfi.dfi_cke_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{dfi.dfi_odt_i, dfi.dfi_wstb_i, cmd_full[FULL_BITS-1:MEM_ABITS], cmd_full[1:0]};

endmodule

// File: tb/tb_ddr3_dfi_responder.sv
// Self-checking bench for ddr3_dfi_responder: table-driven write/read transactions plus
// hand-written sequences for masks, read-first, queue overflow, resets and calibration.
module tb_ddr3_dfi_responder;
    localparam int unsigned RD_LATENCY  = 3;
    localparam int unsigned CALIB_DELAY = 16;
`ifdef DFI_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err;
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    ddr3_dfi_responder_if #(.DDR_ROW_BITS(15), .DDR_DQ_WIDTH(16)) dfi ();

    ddr3_dfi_responder #(
        .DDR_ROW_BITS(15), .DDR_COL_BITS(10), .DDR_DQ_WIDTH(16), .MEM_ABITS(10),
        .RD_LATENCY(RD_LATENCY), .CALIB_DELAY(CALIB_DELAY), .CMD_DEPTH(4)
    ) dut (
        .clock(clk),
        .reset(rst),
        .dfi(dfi.slave),
        .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        chk_last;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]       bank;
        logic [14:0]      row;
        logic [14:0]      col;
        logic [3:0][31:0] wdata;
        logic [3:0][31:0] exp;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Read-return monitor: every rvld beat must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (dfi.dfi_rvld_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got rvld with data 0x%0h expected no beat", dfi.dfi_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_latency", 64'(cyc), 64'(e.due));
                check("rd_data", 64'(dfi.dfi_data_o), 64'(e.data));
                if (e.chk_last) check("rd_last", 64'(dfi.dfi_last_o), 64'(e.last));
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            n_total++;
            $display("FAIL rd_timeout: got no rvld by cycle %0d expected beat 0x%0h", cyc, sb[0].data);
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (RD_LATENCY + 2) tick();
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
        dfi.dfi_cs_ni = 1'b0;
        {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = c;
        dfi.dfi_bank_i = b;
        dfi.dfi_addr_i = a;
        tick();
        dfi.dfi_cs_ni = 1'b1;
        {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = 3'b111;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic last, input logic chk_last);
        exp_t e;
        e.data = d;
        e.last = last;
        e.chk_last = chk_last;
        e.due = cyc + RD_LATENCY;
        sb.push_back(e);
    endtask

    task automatic wr_burst(input logic [3:0][31:0] d, input logic [3:0][3:0] m);
        for (int b = 0; b < 4; b++) begin
            dfi.dfi_wren_i = 1'b1;
            dfi.dfi_data_i = d[b];
            dfi.dfi_mask_i = m[b];
            tick();
        end
        dfi.dfi_wren_i = 1'b0;
        dfi.dfi_mask_i = '0;
    endtask

    task automatic rd_burst(input logic [3:0][31:0] e, input logic chk_last);
        for (int b = 0; b < 4; b++) begin
            dfi.dfi_rden_i = 1'b1;
            push_exp(e[b], b == 3, chk_last);
            tick();
        end
        dfi.dfi_rden_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] b2_data;
        logic [3:0][31:0] new_data;
        logic [3:0][31:0] zeros;
        zeros = '0;
        b2_data = {32'h0000_0044, 32'h0000_0033, 32'hFF00_FF22, 32'h0000_0011};
        new_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

        vecs[0] = '{3'd2, 15'h01A5, 15'h0008,
                    {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011},
                    {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011}};
        vecs[1] = '{3'd0, 15'h0000, 15'h0040,
                    {32'h0BAD_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001},
                    {32'h0BAD_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001}};
        vecs[2] = '{3'd7, 15'h7FFF, 15'h03F8,
                    {32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
                    {32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hF0F0_F0F0}};
        vecs[3] = '{3'd5, 15'h0002, 15'h0010,
                    {32'h7FFF_FFFE, 32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF},
                    {32'h7FFF_FFFE, 32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF}};

        dfi.dfi_rst_ni = 1'b1; dfi.dfi_cke_i = 1'b1; dfi.dfi_cs_ni = 1'b1;
        dfi.dfi_ras_ni = 1'b1; dfi.dfi_cas_ni = 1'b1; dfi.dfi_we_ni = 1'b1;
        dfi.dfi_odt_i = 1'b0; dfi.dfi_bank_i = '0; dfi.dfi_addr_i = '0; dfi.dfi_wstb_i = 1'b0;
        dfi.dfi_wren_i = 1'b0; dfi.dfi_mask_i = '0; dfi.dfi_data_i = '0; dfi.dfi_rden_i = 1'b0;
        dfi.dfi_align_i = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_rvld", 64'(dfi.dfi_rvld_o), 64'd0);
        check("reset_last", 64'(dfi.dfi_last_o), 64'd0);
        check("reset_data", 64'(dfi.dfi_data_o), 64'd0);
        check("reset_calib", 64'(dfi.dfi_calib_o), 64'd0);
        check("reset_err", 64'(err), 64'd0);

        for (int i = 0; i < 4; i++) begin
            do_cmd(C_ACT, vecs[i].bank, vecs[i].row);
            do_cmd(C_WR, vecs[i].bank, vecs[i].col);
            wr_burst(vecs[i].wdata, '0);
            do_cmd(C_RD, vecs[i].bank, vecs[i].col);
            rd_burst(vecs[i].exp, 1'b1);
            drain();
        end

        // Partial-mask write over beat 1 of bank 2, other beats fully masked.
        do_cmd(C_WR, 3'd2, 15'h0008);
        wr_burst({32'h9999_9999, 32'h8888_8888, 32'hFFFF_FFFF, 32'h7777_7777},
                 {4'b1111, 4'b1111, 4'b0101, 4'b1111});
        do_cmd(C_RD, 3'd2, 15'h0008);
        rd_burst(b2_data, 1'b1);
        drain();

        // Simultaneous write and read of the same words return the old contents.
        do_cmd(C_WR, 3'd0, 15'h0040);
        do_cmd(C_RD, 3'd0, 15'h0040);
        for (int b = 0; b < 4; b++) begin
            dfi.dfi_wren_i = 1'b1;
            dfi.dfi_rden_i = 1'b1;
            dfi.dfi_data_i = new_data[b];
            push_exp(vecs[1].exp[b], b == 3, 1'b1);
            tick();
        end
        dfi.dfi_wren_i = 1'b0;
        dfi.dfi_rden_i = 1'b0;
        do_cmd(C_RD, 3'd0, 15'h0040);
        rd_burst(new_data, 1'b1);
        drain();
        check("err_clean", 64'(err), 64'd0);

        // Five queued reads: the fifth is dropped, so the fifth burst finds an empty queue.
        for (int i = 0; i < 5; i++) do_cmd(C_RD, 3'd2, 15'h0008);
        for (int i = 0; i < 4; i++) rd_burst(b2_data, 1'b1);
        rd_burst(zeros, 1'b0);
        drain();
        check("err_overflow", 64'(err), 64'(EXP_ERR));

        do_reset();
        check("rst2_err", 64'(err), 64'd0);
        check("rst2_rvld", 64'(dfi.dfi_rvld_o), 64'd0);

        // Precharge-all then read a closed bank: still served from the stale row.
        do_cmd(C_ACT, 3'd2, 15'h01A5);
        do_cmd(C_PRE, 3'd0, 15'h0400);
        check("err_pre_all", 64'(err), 64'd0);
        do_cmd(C_RD, 3'd2, 15'h0008);
        check("err_closed_bank", 64'(err), 64'(EXP_ERR));
        rd_burst(b2_data, 1'b1);
        drain();

        // Reset while the first beat of a burst is on the outputs.
        do_reset();
        do_cmd(C_ACT, 3'd2, 15'h01A5);
        do_cmd(C_RD, 3'd2, 15'h0008);
        dfi.dfi_rden_i = 1'b1;
        push_exp(b2_data[0], 1'b0, 1'b1);
        tick();
        push_exp(b2_data[1], 1'b0, 1'b1);
        tick();
        dfi.dfi_rden_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rvld", 64'(dfi.dfi_rvld_o), 64'd0);
        check("midrst_last", 64'(dfi.dfi_last_o), 64'd0);
        check("midrst_data", 64'(dfi.dfi_data_o), 64'd0);
        sb.delete();
        do_cmd(C_ACT, 3'd2, 15'h01A5);
        do_cmd(C_RD, 3'd2, 15'h0008);
        rd_burst(b2_data, 1'b1);
        drain();

        // DRAM reset flushes the queued read.
        do_cmd(C_ACT, 3'd2, 15'h01A5);
        do_cmd(C_RD, 3'd2, 15'h0008);
        dfi.dfi_rst_ni = 1'b0;
        tick();
        dfi.dfi_rst_ni = 1'b1;
        rd_burst(zeros, 1'b0);
        drain();

        // Calibration handshake.
        dfi.dfi_align_i = 1'b1;
        repeat (CALIB_DELAY - 1) tick();
        check("calib_early", 64'(dfi.dfi_calib_o), 64'd0);
        tick();
        check("calib_done", 64'(dfi.dfi_calib_o), 64'd1);
        repeat (3) tick();
        check("calib_hold", 64'(dfi.dfi_calib_o), 64'd1);
        dfi.dfi_align_i = 1'b0;
        tick();
        check("calib_drop", 64'(dfi.dfi_calib_o), 64'd0);
        tick();
        dfi.dfi_align_i = 1'b1;
        repeat (5) tick();
        do_reset();
        repeat (CALIB_DELAY - 4) tick();
        check("calib_rst_wait", 64'(dfi.dfi_calib_o), 64'd0);
        dfi.dfi_align_i = 1'b0;
        tick();

        drain();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
